// File: rtl/bconv_pkg.sv
// bconv_pkg: shared definitions for the binary convolution stream.
//   state_e      - frame FSM states (IDLE, FILL, STREAM)
//   MAX_K        - largest supported kernel size
//   MAX_CNT_W    - popcount width for the largest kernel
//   CNT_W        - popcount width for the default 3x3 kernel
//   calc_cnt_w() - popcount width for a given kernel size, $clog2(K*K+1)
//   popcount()   - ones count over a MAX_K*MAX_K window vector
package bconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam int unsigned MAX_K     = 5;
  localparam int unsigned MAX_CNT_W = $clog2(MAX_K * MAX_K + 1);
  localparam int unsigned CNT_W     = $clog2(3 * 3 + 1);

  function automatic int unsigned calc_cnt_w(input int unsigned k);
    return $clog2(k * k + 1);
  endfunction

  // Unused upper bits of the window vector must be zero.
  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_K*MAX_K-1:0] v);
    logic [MAX_CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_K * MAX_K; i++) begin
      n = n + MAX_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bconv_line_buffer.sv
// bconv_line_buffer: K-row shift buffer of binary image rows.
//   clk      - clock, rising edge
//   wr_en_i  - shift row_i in as the newest row
//   row_i    - incoming row, bit j is column j
//   rows_o   - buffered rows, rows_o[0] oldest, rows_o[K-1] newest
// Contents are not reset; the fill phase of every frame overwrites them.
module bconv_line_buffer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned K     = 3
) (
  input  logic                      clk,
  input  logic                      wr_en_i,
  input  logic [IMG_W-1:0]          row_i,
  output logic [K-1:0][IMG_W-1:0]   rows_o
);

  logic [K-1:0][IMG_W-1:0] rows_q;
  logic [K-1:0][IMG_W-1:0] rows_d;

  always_comb begin
    rows_d = rows_q;
    if (wr_en_i) begin
      for (int unsigned i = 0; i < K - 1; i++) begin
        rows_d[i] = rows_q[i+1];
      end
      rows_d[K-1] = row_i;
    end
  end

  always_ff @(posedge clk) begin
    rows_q <= rows_d;
  end

  assign rows_o = rows_q;

endmodule

// File: rtl/bconv_stream.sv
// bconv_stream: streaming binary (XNOR-popcount) 2-D convolution.
// Rows arrive one per handshake; after K-1 fill rows every accepted row
// yields one registered output row of N_CH x OW popcounts.
//   clk, rst_n            - clock, synchronous active-low reset
//   start_i               - frame start pulse (IDLE only), latches kernels
//   kernel_i              - [ch][r][c] binary kernels
//   row_i                 - input row, bit j is column j
//   row_valid_i/row_ready_o - input row handshake
//   out_o                 - [ch][x] popcounts of the presented output row
//   out_valid_o/out_ready_i - output row handshake
//   out_row_o             - index of the presented output row
//   busy_o                - frame in progress
//   frame_done_o          - one-cycle pulse when the last output row is taken
// Optional feature, macro BCONV_THRESH_EN: adds thresh_i [ch] (latched at
// start_i) and bin_o [ch][x] = (out_o[ch][x] >= thresh[ch]).
module bconv_stream
  import bconv_pkg::*;
#(
  parameter  int unsigned IMG_W = 28,
  parameter  int unsigned IMG_H = 28,
  parameter  int unsigned K     = 3,
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned OW    = IMG_W - K + 1,
  localparam int unsigned OH    = IMG_H - K + 1,
  localparam int unsigned CNT_W = calc_cnt_w(K),
  localparam int unsigned OR_W  = (OH > 1) ? $clog2(OH) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic [N_CH-1:0][K-1:0][K-1:0]       kernel_i,
`ifdef BCONV_THRESH_EN
  input  logic [N_CH-1:0][CNT_W-1:0]          thresh_i,
  output logic [N_CH-1:0][OW-1:0]             bin_o,
`endif
  input  logic [IMG_W-1:0]                    row_i,
  input  logic                                row_valid_i,
  output logic                                row_ready_o,
  output logic [N_CH-1:0][OW-1:0][CNT_W-1:0]  out_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [OR_W-1:0]                     out_row_o,
  output logic                                busy_o,
  output logic                                frame_done_o
);

  localparam int unsigned FC_W = (K > 2) ? $clog2(K - 1) : 1;
  localparam int unsigned OC_W = $clog2(OH + 1);

  state_e                               state_q, state_d;
  logic [N_CH-1:0][K-1:0][K-1:0]        kernel_q, kernel_d;
  logic [FC_W-1:0]                      fill_cnt_q, fill_cnt_d;
  logic [OC_W-1:0]                      out_cnt_q, out_cnt_d;
  logic [N_CH-1:0][OW-1:0][CNT_W-1:0]   out_q, out_d;
  logic                                 out_valid_q, out_valid_d;
  logic [OR_W-1:0]                      out_row_q, out_row_d;
  logic                                 busy_q, busy_d;
  logic                                 frame_done_q, frame_done_d;

  logic                                 row_ready;
  logic                                 accept;
  logic                                 consume;
  logic [K-1:0][IMG_W-1:0]              rows;
  logic [K-1:0][IMG_W-1:0]              win;
  logic [MAX_K*MAX_K-1:0]               vec;
  logic [N_CH-1:0][OW-1:0][CNT_W-1:0]   cnt_nxt;

`ifdef BCONV_THRESH_EN
  logic [N_CH-1:0][CNT_W-1:0]           thresh_q, thresh_d;
  logic [N_CH-1:0][OW-1:0]              bin_q, bin_d;
  logic [N_CH-1:0][OW-1:0]              bin_nxt;
`endif

  bconv_line_buffer #(
    .IMG_W (IMG_W),
    .K     (K)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en_i (accept),
    .row_i   (row_i),
    .rows_o  (rows)
  );

  // Once all OH output rows have been launched no further rows belong to
  // this frame, so the input side closes until the next start.
  always_comb begin
    row_ready = 1'b0;
    unique case (state_q)
      ST_FILL:   row_ready = 1'b1;
      ST_STREAM: row_ready = (out_cnt_q < OC_W'(OH)) && (!out_valid_q || out_ready_i);
      default:   row_ready = 1'b0;
    endcase
  end

  assign accept  = row_valid_i && row_ready;
  assign consume = out_valid_q && out_ready_i;

  // The output is registered on the accepting edge, so the window is the
  // buffer as it will be after the shift: rows 1..K-1 plus the incoming row.
  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < K - 1; r++) begin
      win[r] = rows[r+1];
    end
    win[K-1] = row_i;

    vec     = '0;
    cnt_nxt = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      for (int unsigned x = 0; x < OW; x++) begin
        vec = '0;
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K; c++) begin
            vec[r*K+c] = ~(win[r][x+c] ^ kernel_q[ch][r][c]);
          end
        end
        cnt_nxt[ch][x] = CNT_W'(popcount(vec));
      end
    end
  end

`ifdef BCONV_THRESH_EN
  always_comb begin
    bin_nxt = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      for (int unsigned x = 0; x < OW; x++) begin
        bin_nxt[ch][x] = (cnt_nxt[ch][x] >= thresh_q[ch]);
      end
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    kernel_d     = kernel_q;
    fill_cnt_d   = fill_cnt_q;
    out_cnt_d    = out_cnt_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef BCONV_THRESH_EN
    thresh_d     = thresh_q;
    bin_d        = bin_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          kernel_d   = kernel_i;
`ifdef BCONV_THRESH_EN
          thresh_d   = thresh_i;
`endif
          fill_cnt_d = '0;
          out_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        if (accept) begin
          if (fill_cnt_q == FC_W'(K - 2)) begin
            fill_cnt_d = '0;
            state_d    = ST_STREAM;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (accept) begin
          out_d       = cnt_nxt;
`ifdef BCONV_THRESH_EN
          bin_d       = bin_nxt;
`endif
          out_valid_d = 1'b1;
          out_row_d   = OR_W'(out_cnt_q);
          out_cnt_d   = out_cnt_q + 1'b1;
        end else if (consume) begin
          out_valid_d = 1'b0;
        end
        if (consume && (out_row_q == OR_W'(OH - 1))) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          fill_cnt_d   = '0;
          out_cnt_d    = '0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    kernel_q <= kernel_d;
`ifdef BCONV_THRESH_EN
    thresh_q <= thresh_d;
`endif
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= '0;
      out_cnt_q    <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef BCONV_THRESH_EN
      bin_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      out_cnt_q    <= out_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef BCONV_THRESH_EN
      bin_q        <= bin_d;
`endif
    end
  end

  assign row_ready_o  = row_ready;
  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign out_row_o    = out_row_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
`ifdef BCONV_THRESH_EN
  assign bin_o        = bin_q;
`endif

endmodule
